// File: rtl/dmem_arbiter.sv
// Purpose: shares the single data-memory port between the CPU Memory stage (port 0) and a boot-loader/DMA writer (port 1).
// Latency: grant is combinational in the request cycle; read data and rvalid follow one cycle after the grant.
// Backpressure: a denied port holds req/addr/data stable until granted; a burst lock or a starvation override decides ownership.
// Optional feature: define ARB_PERF_CNT_EN to build the grant/conflict counters (otherwise the counter outputs are tied to 0).
module dmem_arbiter #(
    parameter int AW         = 14,
    parameter int DW         = 32,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_WAIT   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [3:0]    we0,
    input  logic [3:0]    we1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          starve_evt,
    output logic [31:0]   grant_cnt0,
    output logic [31:0]   grant_cnt1,
    output logic [31:0]   conflict_cnt
);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic [7:0] wait0;
    logic [7:0] wait1;
    logic       starve0;
    logic       starve1;

    // A port that has waited MAX_WAIT cycles and is still requesting must win next.
    assign starve0 = req0 && (wait0 == MAX_W);
    assign starve1 = req1 && (wait1 == MAX_W);

    // Grant selection and next state; nothing is granted while reset is held.
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        starve_evt = 1'b0;
        state_nxt  = state;
        if (rst) begin
            if (starve0) begin
                // Override beats priority and any lock held by port 1.
                gnt0       = 1'b1;
                starve_evt = 1'b1;
                state_nxt  = lock0 ? OWN0 : ARB;
            end else if (starve1) begin
                gnt1       = 1'b1;
                starve_evt = 1'b1;
                state_nxt  = lock1 ? OWN1 : ARB;
            end else begin
                case (state)
                    ARB: begin
                        if (req0 && req1) begin
                            // last_grant == 1 means port 1 went last, so port 0 is next.
                            if ((FIXED_PRIO != 0) || last_grant) begin
                                gnt0 = 1'b1;
                            end else begin
                                gnt1 = 1'b1;
                            end
                        end else begin
                            gnt0 = req0;
                            gnt1 = req1;
                        end
                        if (gnt0 && lock0) begin
                            state_nxt = OWN0;
                        end else if (gnt1 && lock1) begin
                            state_nxt = OWN1;
                        end
                    end
                    OWN0: begin
                        gnt0 = req0;
                        // Released either on an unlocked beat or when idle and unlocked.
                        if (!lock0) begin
                            state_nxt = ARB;
                        end
                    end
                    OWN1: begin
                        gnt1 = req1;
                        if (!lock1) begin
                            state_nxt = ARB;
                        end
                    end
                    default: state_nxt = ARB;
                endcase
            end
        end
    end

    // Memory port driven from whichever port holds the grant, zero when idle.
    always_comb begin
        mem_en   = gnt0 | gnt1;
        mem_we   = '0;
        mem_addr = '0;
        mem_din  = '0;
        if (gnt0) begin
            mem_we   = we0;
            mem_addr = addr0;
            mem_din  = wdata0;
        end else if (gnt1) begin
            mem_we   = we1;
            mem_addr = addr1;
            mem_din  = wdata1;
        end
    end

    // Read data is only presented while a read response is due.
    assign rdata = (rvalid0 || rvalid1) ? mem_dout : '0;

    // Ownership state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // Round-robin history, read-response flags and saturating wait counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            wait0      <= '0;
            wait1      <= '0;
        end else begin
            if (gnt0) begin
                last_grant <= 1'b0;
            end else if (gnt1) begin
                last_grant <= 1'b1;
            end
            rvalid0 <= gnt0 && (we0 == 4'h0);
            rvalid1 <= gnt1 && (we1 == 4'h0);
            if (!req0 || gnt0) begin
                wait0 <= '0;
            end else if (wait0 != MAX_W) begin
                wait0 <= wait0 + 8'd1;
            end
            if (!req1 || gnt1) begin
                wait1 <= '0;
            end else if (wait1 != MAX_W) begin
                wait1 <= wait1 + 8'd1;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    // Free-running wrapping grant and contention counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt0   <= '0;
            grant_cnt1   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (gnt0) begin
                grant_cnt0 <= grant_cnt0 + 32'd1;
            end
            if (gnt1) begin
                grant_cnt1 <= grant_cnt1 + 32'd1;
            end
            if (req0 && req1) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
        end
    end
`else
    assign grant_cnt0   = '0;
    assign grant_cnt1   = '0;
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances cover round-robin/MAX_WAIT=8,
// fixed priority/MAX_WAIT=8 and round-robin/MAX_WAIT=3; only the selected one sees requests.
module tb_dmem_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [3:0]    we0, we1;
    logic [DW-1:0] mem_dout;
    logic [1:0]    sel;

    logic          g0 [3];
    logic          g1 [3];
    logic          rv0 [3];
    logic          rv1 [3];
    logic          men [3];
    logic          stv [3];
    logic [DW-1:0] rd [3];
    logic [DW-1:0] mdin [3];
    logic [3:0]    mwe [3];
    logic [AW-1:0] madr [3];
    logic [31:0]   gc0 [3];
    logic [31:0]   gc1 [3];
    logic [31:0]   cc [3];

    logic          gnt0_s, gnt1_s, rv0_s, rv1_s, men_s, stv_s;
    logic [DW-1:0] rd_s, mdin_s;
    logic [3:0]    mwe_s;
    logic [AW-1:0] madr_s;

    logic [DW-1:0] mem_m [0:511];

    int checks = 0;
    int errors = 0;
    logic pend0 = 1'b0;
    logic pend1 = 1'b0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam logic [1:0] K = 2'(k);
        dmem_arbiter #(
            .AW(AW),
            .DW(DW),
            .FIXED_PRIO(k == 1 ? 1 : 0),
            .MAX_WAIT(k == 2 ? 3 : 8)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .req0(req0 && (sel == K)),
            .req1(req1 && (sel == K)),
            .lock0(lock0),
            .lock1(lock1),
            .addr0(addr0),
            .addr1(addr1),
            .wdata0(wdata0),
            .wdata1(wdata1),
            .we0(we0),
            .we1(we1),
            .gnt0(g0[k]),
            .gnt1(g1[k]),
            .rvalid0(rv0[k]),
            .rvalid1(rv1[k]),
            .rdata(rd[k]),
            .mem_en(men[k]),
            .mem_we(mwe[k]),
            .mem_addr(madr[k]),
            .mem_din(mdin[k]),
            .mem_dout(mem_dout),
            .starve_evt(stv[k]),
            .grant_cnt0(gc0[k]),
            .grant_cnt1(gc1[k]),
            .conflict_cnt(cc[k])
        );
    end

    // Observe the instance under test.
    always_comb begin
        gnt0_s = g0[sel];
        gnt1_s = g1[sel];
        rv0_s  = rv0[sel];
        rv1_s  = rv1[sel];
        men_s  = men[sel];
        stv_s  = stv[sel];
        rd_s   = rd[sel];
        mdin_s = mdin[sel];
        mwe_s  = mwe[sel];
        madr_s = madr[sel];
    end

    // 1-cycle synchronous RAM; preloaded with {C0DE, addr} (0x010 = DEADBEEF) while in reset.
    always @(posedge clk) begin
        if (!rst) begin
            for (int a = 0; a < 512; a++) mem_m[a] <= {16'hC0DE, 16'(a)};
            mem_m[16] <= 32'hDEADBEEF;
            mem_dout  <= '0;
        end else if (men_s) begin
            if (mwe_s == 4'h0) begin
                mem_dout <= mem_m[madr_s[8:0]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mwe_s[b]) mem_m[madr_s[8:0]][8*b +: 8] <= mdin_s[8*b +: 8];
            end
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; remember which requests were left waiting.
    task tick();
        pend0 = rst && req0 && !gnt0_s;
        pend1 = rst && req1 && !gnt1_s;
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle, then confirm no waiting request was dropped.
    task settle();
        #2;
        if (pend0 && rst) chk1("req0_hold", req0, 1'b1);
        if (pend1 && rst) chk1("req1_hold", req1, 1'b1);
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; we0 = '0; we1 = '0;
        sel = 2'd0;
        #1 rst = 1'b0;
        #2 req0 = 1'b1; addr0 = 14'h010;
        #1;
        // Reset state, with a request already pending.
        chk1("rst_gnt0", gnt0_s, 1'b0);
        chk1("rst_gnt1", gnt1_s, 1'b0);
        chk1("rst_rvalid0", rv0_s, 1'b0);
        chk1("rst_rvalid1", rv1_s, 1'b0);
        chkw("rst_rdata", rd_s, 32'h0);
        chk1("rst_mem_en", men_s, 1'b0);
        chkw("rst_mem_we", 32'(mwe_s), 32'h0);
        chkw("rst_mem_addr", 32'(madr_s), 32'h0);
        chkw("rst_mem_din", mdin_s, 32'h0);
        chk1("rst_starve", stv_s, 1'b0);
        tick(); settle();
        chk1("rst_hold_gnt0", gnt0_s, 1'b0);
        chk1("rst_hold_mem_en", men_s, 1'b0);

        // Solo read of 0x010.
        tick(); rst = 1'b1; settle();
        chk1("solo_gnt0", gnt0_s, 1'b1);
        chk1("solo_gnt1", gnt1_s, 1'b0);
        chk1("solo_mem_en", men_s, 1'b1);
        chkw("solo_mem_addr", 32'(madr_s), 32'h010);
        chkw("solo_mem_we", 32'(mwe_s), 32'h0);
        // Read response, plus a solo port-1 write.
        tick(); req0 = 1'b0; req1 = 1'b1; addr1 = 14'h020; we1 = 4'hF; wdata1 = 32'h11112222; settle();
        chk1("solo_rvalid0", rv0_s, 1'b1);
        chkw("solo_rdata", rd_s, 32'hDEADBEEF);
        chk1("solo_rvalid1", rv1_s, 1'b0);
        chk1("wr1_gnt1", gnt1_s, 1'b1);
        chk1("wr1_gnt0", gnt0_s, 1'b0);
        chkw("wr1_mem_din", mdin_s, 32'h11112222);
        chkw("wr1_mem_we", 32'(mwe_s), 32'hF);
        chkw("wr1_mem_addr", 32'(madr_s), 32'h020);

        // Round-robin tie: port 0 writes 0x040, port 1 reads 0x030; grants 0,1,0,1.
        tick();
        req0 = 1'b1; addr0 = 14'h040; we0 = 4'hF; wdata0 = 32'hA5A5A5A5;
        req1 = 1'b1; addr1 = 14'h030; we1 = 4'h0;
        settle();
        chk1("wr1_no_rvalid1", rv1_s, 1'b0);
        chk1("rr0_gnt0", gnt0_s, 1'b1);
        chk1("rr0_gnt1", gnt1_s, 1'b0);
        chk1("rr0_starve", stv_s, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick(); settle();
            chk1("rr_gnt0", gnt0_s, (i % 2) == 0);
            chk1("rr_gnt1", gnt1_s, (i % 2) == 1);
            chk1("rr_starve", stv_s, 1'b0);
            chk1("rr_rvalid1", rv1_s, i == 2);
            chkw("rr_rdata", rd_s, (i == 2) ? 32'hC0DE0030 : 32'h0);
        end
        tick(); req1 = 1'b0; settle();
        chk1("rr_tail_gnt0", gnt0_s, 1'b1);
        chk1("rr_tail_rvalid1", rv1_s, 1'b1);
        chkw("rr_tail_rdata", rd_s, 32'hC0DE0030);

        // Lock burst: port 1 writes 0x100..0x104 locked while port 0 keeps requesting a read.
        for (int i = 0; i < 5; i++) begin
            tick();
            req0 = 1'b1; addr0 = 14'h050; we0 = 4'h0;
            req1 = 1'b1; lock1 = (i != 4); addr1 = 14'(32'h100 + i); we1 = 4'hF;
            wdata1 = 32'hB0000000 + 32'(i);
            settle();
            chk1("lk_gnt1", gnt1_s, 1'b1);
            chk1("lk_gnt0", gnt0_s, 1'b0);
            chkw("lk_mem_din", mdin_s, 32'hB0000000 + 32'(i));
            chkw("lk_mem_addr", 32'(madr_s), 32'h100 + 32'(i));
        end
        tick(); req1 = 1'b0; lock1 = 1'b0; settle();
        chk1("lk_after_gnt0", gnt0_s, 1'b1);
        chk1("lk_after_gnt1", gnt1_s, 1'b0);
        chkw("lk_after_addr", 32'(madr_s), 32'h050);
        chk1("lk_after_starve", stv_s, 1'b0);
        tick(); req0 = 1'b0; req1 = 1'b1; addr1 = 14'h102; we1 = 4'h0; settle();
        chk1("lk_rd_rvalid0", rv0_s, 1'b1);
        chkw("lk_rd_rdata0", rd_s, 32'hC0DE0050);
        chk1("lk_rd_gnt1", gnt1_s, 1'b1);
        tick(); req1 = 1'b0; settle();
        chk1("lk_rd_rvalid1", rv1_s, 1'b1);
        chkw("lk_rd_rdata1", rd_s, 32'hB0000002);

        // Asynchronous reset in the cycle after a read grant.
        tick(); req0 = 1'b1; addr0 = 14'h010; we0 = 4'h0; settle();
        chk1("mr_gnt0", gnt0_s, 1'b1);
        tick(); rst = 1'b0; addr0 = 14'h060; req1 = 1'b1; addr1 = 14'h070; we1 = 4'h0; settle();
        chk1("mr_rvalid0", rv0_s, 1'b0);
        chkw("mr_rdata", rd_s, 32'h0);
        chk1("mr_gnt0_off", gnt0_s, 1'b0);
        chk1("mr_gnt1_off", gnt1_s, 1'b0);
        chk1("mr_mem_en", men_s, 1'b0);
        chkw("mr_mem_addr", 32'(madr_s), 32'h0);
        chk1("mr_starve", stv_s, 1'b0);
        tick(); settle();
        chk1("mr_hold_rvalid0", rv0_s, 1'b0);
        chk1("mr_hold_mem_en", men_s, 1'b0);
        tick(); rst = 1'b1; settle();
        chk1("mr_tie_gnt0", gnt0_s, 1'b1);
        chk1("mr_tie_gnt1", gnt1_s, 1'b0);
        chkw("mr_tie_addr", 32'(madr_s), 32'h060);
        tick(); req0 = 1'b0; settle();
        chk1("mr_post_rvalid0", rv0_s, 1'b1);
        chkw("mr_post_rdata0", rd_s, 32'hC0DE0060);
        chk1("mr_post_gnt1", gnt1_s, 1'b1);
        tick(); req1 = 1'b0; settle();
        chk1("mr_post_rvalid1", rv1_s, 1'b1);
        chkw("mr_post_rdata1", rd_s, 32'hC0DE0070);

        // Fixed priority, MAX_WAIT=8: port 0 eight times, forced port 1, then port 0.
        for (int i = 1; i <= 10; i++) begin
            tick();
            sel = 2'd1;
            req0 = 1'b1; addr0 = 14'h080; we0 = 4'hF; wdata0 = 32'h0F0F0F0F;
            req1 = 1'b1; addr1 = 14'h090; we1 = 4'hF; wdata1 = 32'hF0F0F0F0;
            settle();
            chk1("fp_gnt0", gnt0_s, i != 9);
            chk1("fp_gnt1", gnt1_s, i == 9);
            chk1("fp_starve", stv_s, i == 9);
        end
        tick(); req0 = 1'b0; settle();
        chk1("fp_tail_gnt1", gnt1_s, 1'b1);
        chk1("fp_tail_starve", stv_s, 1'b0);

        // Starvation, MAX_WAIT=3: port 1 owns the port with a lock while port 0 waits.
        tick(); sel = 2'd2; req1 = 1'b1; lock1 = 1'b1; addr1 = 14'h0A0; we1 = 4'hF; wdata1 = 32'h12345678; settle();
        chk1("sv_lock_gnt1", gnt1_s, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick(); req0 = 1'b1; addr0 = 14'h0B0; we0 = 4'hF; wdata0 = 32'hC0C0C0C0; settle();
            chk1("sv_gnt0", gnt0_s, i == 4);
            chk1("sv_gnt1", gnt1_s, i != 4);
            chk1("sv_starve", stv_s, i == 4);
        end
        for (int i = 0; i < 3; i++) begin
            tick(); req0 = 1'b0; lock1 = (i != 2); settle();
            chk1("sv_regnt_gnt1", gnt1_s, 1'b1);
            chk1("sv_regnt_gnt0", gnt0_s, 1'b0);
            chk1("sv_regnt_starve", stv_s, 1'b0);
        end
        tick(); req1 = 1'b0; settle();
        chk1("sv_idle_mem_en", men_s, 1'b0);

`ifdef ARB_PERF_CNT_EN
        chkw("perf_gc0", gc0[1], 32'd9);
        chkw("perf_gc1", gc1[1], 32'd2);
        chkw("perf_conflict", cc[1], 32'd10);
`else
        chkw("perf_gc0_tied", gc0[0], 32'h0);
        chkw("perf_gc1_tied", gc1[0], 32'h0);
        chkw("perf_conflict_tied", cc[1], 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (dmem/imem write side) between two requesters.
  - Port 0: the CPU Memory stage.
  - Port 1: a UART boot loader / DMA engine that writes program images.
- Single-cycle request/grant handshake, round-robin or fixed priority, optional burst lock, and a starvation guard.
- Read data returns one cycle after grant, matching the 1-cycle synchronous RAM.

Parameters:
- AW, 14, word-address width of the shared memory port
- DW, 32, data width
- FIXED_PRIO, 0, 1 = port 0 always wins ties; 0 = round-robin
- MAX_WAIT, 8, cycles a requesting port may be denied before it is forced to win (range 1..255)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req0, req1  in  1  access request; must stay asserted, with address/data/byte-enables stable, until granted
- lock0, lock1  in  1  burst lock; sampled with req while the port is owner
- addr0, addr1  in  AW  word address
- wdata0, wdata1  in  DW  write data
- we0, we1  in  4  byte write enables; 0 = read
- gnt0, gnt1  out  1  access accepted this cycle (combinational)
- rvalid0, rvalid1  out  1  read data valid (registered)
- rdata  out  DW  read data, shared by both ports
- mem_en  out  1  memory enable
- mem_we  out  4  memory byte write enables
- mem_addr  out  AW  memory address
- mem_din  out  DW  memory write data
- mem_dout  in  DW  memory read data; valid one cycle after mem_en
- starve_evt  out  1  one-cycle pulse when a starvation override fires

Behaviour:
- Reset values:
  - All outputs 0: gnt*, rvalid*, rdata, mem_*, starve_evt.
  - FSM enters ARB.
  - last_grant = 1, so port 0 wins the first tie.
  - Wait counters are 0.
- FSM states:
  - ARB: no owner.
  - OWN0 / OWN1: port holds a lock.
- Arbitration in ARB:
  - Only one req: that port is granted.
  - Both req, FIXED_PRIO=1: port 0 is granted.
  - Both req, FIXED_PRIO=0: the port != last_grant is granted.
  - Starvation override has top priority.
- Lock:
  - If the granted port has lock=1 in the grant cycle, go to OWNn.
  - In OWNn, only port n is granted, whenever reqn=1.
  - Return to ARB on the first cycle port n is granted with lockn=0, or on the first cycle reqn=0 and lockn=0.
- Grant:
  - At most one gnt per cycle.
  - gnt is asserted in the same cycle as req when selected.
  - mem_en = any gnt.
  - mem_addr, mem_din and mem_we are muxed from the granted port; all 0 when there is no grant.
  - last_grant updates on every grant.
- Read response:
  - A granted read (we==0) sets rvalidn the next cycle.
  - rdata = mem_dout while either rvalid is high, otherwise 0.
  - Writes produce no rvalid.
  - Back-to-back grants sustain one access per cycle, so rvalid may stay high on consecutive cycles.
- Starvation guard:
  - waitn increments on each cycle reqn=1 && gntn=0.
  - It clears on gntn, or when reqn=0.
  - It saturates at MAX_WAIT.
  - When waitn == MAX_WAIT, port n is granted next, overriding priority and any lock held by the other port.
  - In that case the FSM returns to ARB, or to OWNn if lockn=1.
  - starve_evt pulses in the override cycle.
- Simultaneous starvation of both ports is impossible: one port is granted every contended cycle.
- Reset mid-operation: a pending rvalid is dropped, the lock is released, and counters clear; no mem_en is issued during reset.
- A request deasserted before grant is illegal, and behaviour is undefined. The bench checks with an assertion.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined:
  - Two 32-bit wrapping counters, grant_cnt0 and grant_cnt1, increment on each gntn. They reset to 0.
  - The counters are exposed as outputs.
  - A third counter, conflict_cnt, counts cycles with req0 && req1.
- Not defined:
  - The same output ports exist, tied to 0.
  - No counter flops are synthesized.

Test Plan:
- Solo read: req0=1, addr0=0x010, we0=0 for one cycle, with mem model returning 0xDEADBEEF -> gnt0 in the same cycle, mem_addr=0x010, mem_en=1; next cycle rvalid0=1, rdata=0xDEADBEEF; rvalid1=0.
- Round-robin tie: FIXED_PRIO=0, req0 and req1 continuously asserted for 4 cycles -> grants 0,1,0,1; no starve_evt.
- Lock burst:
  - Stimulus: port 1 requests with lock1=1 for 5 writes to 0x100..0x104 with we1=4'hF, while req0=1 throughout.
  - Expected: gnt1 for 5 cycles, with mem_din following wdata1.
  - Expected: gnt0 in cycle 6, after lock1=0 on the last beat.
- Starvation: MAX_WAIT=3; port 1 holds lock1 and req1 forever while req0=1 -> gnt0 forced on the 4th denied-cycle boundary; starve_evt pulses once; port 1 re-granted after.
- Fixed priority: FIXED_PRIO=1, both ports request for 10 cycles, MAX_WAIT=8 -> gnt0 for 8 cycles, then gnt1 once with starve_evt=1, then gnt0.
- Async reset mid-read: rst low in the cycle after a read grant -> rvalid0 stays 0, all outputs 0 immediately; after release, a tie grants port 0 first.
